dodger_control: RTL and testbench
=================================

DODGER_CONTROL -- requirements
Module: dodger_control

Interface
REQ-001 Parameter FRAME_CYCLES, default 833333; clock cycles per frame (50 MHz / 60).
REQ-002 Parameter PLAYER_X, default 10; fixed left column of the player sprite.
REQ-003 Parameter SPRITE_W, default 4; sprite edge in pixels; sprites are SPRITE_W x SPRITE_W.
REQ-004 clock  input  1  system clock, 50 MHz.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  synchronous active-high request to begin or restart a game.
REQ-007 finish  input  1  datapath flag: obstacle has passed the player.
REQ-008 obs_x  input  8  obstacle left column.
REQ-009 obs_y  input  7  obstacle top row.
REQ-010 player_y  input  7  player top row.
REQ-011 draw  output  1  advance-pixel enable to the datapath draw counter.
REQ-012 erase  output  1  high while the current pixel writes background colour.
REQ-013 plot  output  1  VGA adapter write enable.
REQ-014 pix_idx  output  4  pixel index within the sprite: [1:0] is the x offset, [3:2] is the y offset.
REQ-015 setoff  output  1  enables datapath motion timing.
REQ-016 frame_tick  output  1  one-cycle pulse once per frame.
REQ-017 score  output  8  obstacles cleared in the current game.
REQ-018 game_over  output  1  high while in state OVER.

Function
REQ-019 States SHALL be IDLE, DRAW, WAIT, ERASE and OVER, encoded in 3 bits.
REQ-020 IDLE with start=1 SHALL go to DRAW on the next edge, clear score, and clear pix_idx.
REQ-021 DRAW SHALL last exactly SPRITE_W*SPRITE_W cycles with draw=1, plot=1, erase=0, and pix_idx incrementing 0..15.
REQ-022 DRAW SHALL go to WAIT after the cycle with pix_idx=15.
REQ-023 WAIT SHALL hold plot=0 and draw=0 until a tick is pending.
REQ-024 When a tick is pending in WAIT and collision is true, the FSM SHALL go to OVER; otherwise it SHALL go to ERASE.
REQ-025 The pending-tick flag SHALL be consumed on the WAIT exit.
REQ-026 ERASE SHALL last 16 cycles with plot=1, erase=1, draw=1, and pix_idx 0..15, then go to DRAW with pix_idx=0.
REQ-027 The frame counter SHALL run only while setoff=1.
REQ-028 The frame counter SHALL load FRAME_CYCLES-1 and pulse frame_tick for one cycle at 0, then reload.
REQ-029 A frame_tick arriving in DRAW or ERASE SHALL set the pending-tick flag, and that tick SHALL be honoured on the next WAIT entry.
REQ-030 More than one tick while pending SHALL collapse to a single pending tick.
REQ-031 setoff SHALL be 1 in DRAW, WAIT and ERASE, and 0 in IDLE and OVER.
REQ-032 Collision SHALL be true iff the column ranges [PLAYER_X, PLAYER_X+3] and [obs_x, obs_x+3] overlap AND the row ranges [player_y, player_y+3] and [obs_y, obs_y+3] overlap.
REQ-033 Collision bounds SHALL be computed at 9/8-bit width so that obs_x>=252 or y>=124 does not wrap.
REQ-034 On a WAIT exit to ERASE with finish=1, score SHALL increment by 1, saturating at 255.
REQ-035 A collision and finish=1 on the same tick SHALL go to OVER with no score increment.
REQ-036 In OVER, game_over SHALL be 1, plot=0, and score SHALL hold.
REQ-037 OVER with start=1 SHALL go to DRAW and clear score.
REQ-038 start SHALL be ignored in DRAW, WAIT and ERASE.

Reset
REQ-039 On resetn=0, the FSM SHALL immediately enter IDLE.
REQ-040 On resetn=0, all outputs SHALL immediately go to 0: draw, erase, plot, pix_idx, setoff, frame_tick, score and game_over.
REQ-041 On resetn=0, the frame counter SHALL load FRAME_CYCLES-1 and the pending-tick flag SHALL clear.
REQ-042 A reset in mid-DRAW or mid-ERASE SHALL abandon the sprite with no further plot pulses.

Structure
REQ-043 State encodings, SPRITE_W and the default FRAME_CYCLES SHALL live in shared include dodger_defs.
REQ-044 The frame counter SHALL be the single sub-module frame_ticker, with ports clock, resetn, enable and tick.
REQ-045 The FSM, pix_idx counter, collision compare and score register SHALL reside in dodger_control.

Verification (FRAME_CYCLES=40)
REQ-046 Scenario: reset, then start pulse -> 16 plot cycles with pix_idx 0..15, then WAIT, setoff=1, score=0.
REQ-047 Scenario: obs_x=50, obs_y=58, player_y=58, finish=1 at the tick -> ERASE 16 cycles with erase=1, then DRAW, score=1.
REQ-048 Scenario: obs_x=12, obs_y=58, player_y=56 at the tick -> OVER, game_over=1, setoff=0, plot stays 0.
REQ-049 Scenario: obs_x=12, player_y=58, finish=1 on the same tick -> OVER, score unchanged.
REQ-050 Scenario: the tick is forced during DRAW -> ERASE begins on the cycle after WAIT entry.
REQ-051 Scenario: resetn=0 at ERASE pix_idx=7 -> all outputs 0 immediately, state IDLE.
REQ-052 Scenario: 256 finish ticks -> score saturates at 255.

Source files
------------

// File: rtl/dodger_control_pkg.sv
// Shared definitions for the dodger game controller: state encodings,
// sprite geometry, default frame length and small arithmetic helpers.
package dodger_control_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAW  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ERASE = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int SPRITE_W_DEF     = 4;
  localparam int FRAME_CYCLES_DEF = 833333;

  // Saturating 8-bit increment used by the score register.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'd255) ? v : v + 8'd1;
  endfunction

  // True when [a_lo, a_lo+len-1] and [b_lo, b_lo+len-1] share a point.
  // Evaluated at 9 bits so screen-edge coordinates do not wrap.
  function automatic logic span_overlap(input logic [8:0] a_lo,
                                        input logic [8:0] b_lo,
                                        input logic [8:0] len);
    return (a_lo <= b_lo + len - 9'd1) && (b_lo <= a_lo + len - 9'd1);
  endfunction

endpackage

// File: rtl/dodger_control_if.sv
// Control <-> datapath bundle: sprite draw strobes out, obstacle/player
// positions and the obstacle-passed flag in.
interface dodger_control_if;
  logic       draw;
  logic       erase;
  logic       plot;
  logic [3:0] pix_idx;
  logic       setoff;
  logic       frame_tick;
  logic       finish;
  logic [7:0] obs_x;
  logic [6:0] obs_y;
  logic [6:0] player_y;

  modport master (
    output draw, erase, plot, pix_idx, setoff, frame_tick,
    input  finish, obs_x, obs_y, player_y
  );

  modport slave (
    input  draw, erase, plot, pix_idx, setoff, frame_tick,
    output finish, obs_x, obs_y, player_y
  );
endinterface

// File: rtl/dodger_control_frame_ticker.sv
// Frame timer: counts down from FRAME_CYCLES-1 while enabled and emits a
// one-cycle tick each time it reaches zero; holds its count when disabled.
module frame_ticker
  import dodger_control_pkg::*;
#(
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEF
) (
  input  logic clock,
  input  logic resetn,
  input  logic enable,
  output logic tick
);

  localparam int              CW     = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0]   RELOAD = CW'(FRAME_CYCLES - 1);

  logic [CW-1:0] count_r;

  // Down-counter with reload and registered tick pulse.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_r <= RELOAD;
      tick    <= 1'b0;
    end else if (enable) begin
      if (count_r == {CW{1'b0}}) begin
        count_r <= RELOAD;
        tick    <= 1'b1;
      end else begin
        count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        tick    <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/dodger_control.sv
// Dodger game controller: sequences sprite draw/erase passes, waits for
// frame ticks, detects player/obstacle collision and keeps the score.
module dodger_control
  import dodger_control_pkg::*;
#(
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int PLAYER_X     = 10,
  parameter int SPRITE_W     = SPRITE_W_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  dodger_control_if.master  dp,
  output logic [7:0]        score,
  output logic              game_over
);

  localparam logic [3:0] PIX_LAST = 4'(SPRITE_W * SPRITE_W - 1);

  state_t     state_r;
  logic       pend_r;
  logic [3:0] pix_r;
  logic       draw_r;
  logic       erase_r;
  logic       plot_r;
  logic       setoff_r;
  logic [7:0] score_r;
  logic       game_over_r;
  logic       tick_s;
  logic       pending_s;
  logic       collide_s;

  frame_ticker #(.FRAME_CYCLES(FRAME_CYCLES)) u_ticker (
    .clock  (clock),
    .resetn (resetn),
    .enable (setoff_r),
    .tick   (tick_s)
  );

  // Bounding-box overlap of player and obstacle, plus the effective tick request.
  always_comb begin
    collide_s = span_overlap(9'(PLAYER_X), {1'b0, dp.obs_x}, 9'(SPRITE_W)) &&
                span_overlap({2'b00, dp.player_y}, {2'b00, dp.obs_y}, 9'(SPRITE_W));
    pending_s = pend_r | tick_s;
  end

  // Game FSM with registered datapath strobes, pixel counter and score.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      pend_r      <= 1'b0;
      pix_r       <= 4'd0;
      draw_r      <= 1'b0;
      erase_r     <= 1'b0;
      plot_r      <= 1'b0;
      setoff_r    <= 1'b0;
      score_r     <= 8'd0;
      game_over_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state_r     <= ST_DRAW;
            pend_r      <= 1'b0;
            pix_r       <= 4'd0;
            draw_r      <= 1'b1;
            plot_r      <= 1'b1;
            erase_r     <= 1'b0;
            setoff_r    <= 1'b1;
            score_r     <= 8'd0;
            game_over_r <= 1'b0;
          end
        end
        ST_DRAW, ST_ERASE: begin
          // Ticks landing mid-sprite are remembered and collapse to one.
          pend_r <= pending_s;
          if (pix_r == PIX_LAST) begin
            pix_r   <= 4'd0;
            erase_r <= 1'b0;
            if (state_r == ST_DRAW) begin
              state_r <= ST_WAIT;
              draw_r  <= 1'b0;
              plot_r  <= 1'b0;
            end else begin
              state_r <= ST_DRAW;
            end
          end else begin
            pix_r <= pix_r + 4'd1;
          end
        end
        ST_WAIT: begin
          if (pending_s) begin
            pend_r <= 1'b0;
            pix_r  <= 4'd0;
            if (collide_s) begin
              state_r     <= ST_OVER;
              setoff_r    <= 1'b0;
              game_over_r <= 1'b1;
            end else begin
              state_r <= ST_ERASE;
              draw_r  <= 1'b1;
              plot_r  <= 1'b1;
              erase_r <= 1'b1;
              if (dp.finish) begin
                score_r <= sat_inc8(score_r);
              end
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          pend_r      <= 1'b0;
          pix_r       <= 4'd0;
          draw_r      <= 1'b0;
          erase_r     <= 1'b0;
          plot_r      <= 1'b0;
          setoff_r    <= 1'b0;
          game_over_r <= 1'b0;
        end
      endcase
    end
  end

  assign dp.draw       = draw_r;
  assign dp.erase      = erase_r;
  assign dp.plot       = plot_r;
  assign dp.pix_idx    = pix_r;
  assign dp.setoff     = setoff_r;
  assign dp.frame_tick = tick_s;
  assign score         = score_r;
  assign game_over     = game_over_r;

endmodule

// File: tb/tb_dodger_control.sv
// Bench for dodger_control: directed scenarios plus random obstacle
// placements, checked against a bounding-box / saturating-score model.
module tb_dodger_control;

  localparam int FC  = 40;
  localparam int FC2 = 10;
  localparam int PX  = 10;

  logic       clock  = 1'b0;
  logic       resetn = 1'b1;
  logic       start  = 1'b0;
  logic       start2 = 1'b0;
  logic [7:0] score, score2;
  logic       game_over, game_over2;

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt   = 0;
  int score_m  = 0;

  dodger_control_if ifa ();
  dodger_control_if ifb ();

  dodger_control #(.FRAME_CYCLES(FC), .PLAYER_X(PX), .SPRITE_W(4)) dut (
    .clock(clock), .resetn(resetn), .start(start), .dp(ifa),
    .score(score), .game_over(game_over)
  );

  // Short frame so that a tick lands while the first sprite is being drawn.
  dodger_control #(.FRAME_CYCLES(FC2), .PLAYER_X(PX), .SPRITE_W(4)) dut2 (
    .clock(clock), .resetn(resetn), .start(start2), .dp(ifb),
    .score(score2), .game_over(game_over2)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; ticks are expected every FC cycles spent with setoff high.
  task automatic step();
    logic en;
    en = ifa.setoff & resetn;
    @(posedge clock);
    if (en) en_cnt++;
    #1;
    chk("frame_tick", 32'(ifa.frame_tick), 32'(en && (en_cnt % FC == 0)));
  endtask

  task automatic sprite(input logic er);
    for (int k = 0; k < 16; k++) begin
      chk(er ? "erase_px" : "draw_px",
          32'({ifa.plot, ifa.draw, ifa.erase, ifa.setoff, ifa.pix_idx}),
          32'({1'b1, 1'b1, er, 1'b1, 4'(k)}));
      step();
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (ifa.frame_tick !== 1'b1 && n < 60) begin
      chk("wait_idle", 32'({ifa.plot, ifa.draw, ifa.setoff}), 32'(3'b001));
      step();
      n++;
    end
    chk("tick_seen", 32'(ifa.frame_tick), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    score_m = 0;
    chk("start_clr", 32'({ifa.setoff, game_over, score}), 32'({1'b1, 1'b0, 8'd0}));
  endtask

  // One frame: place obstacle, wait for the tick, check the outcome and
  // return to the waiting state (restarting the game after a collision).
  task automatic round(input int ox, input int oy, input int py, input logic fin);
    bit coll;
    ifa.obs_x    = 8'(ox);
    ifa.obs_y    = 7'(oy);
    ifa.player_y = 7'(py);
    ifa.finish   = fin;
    coll = (PX <= ox + 3) && (ox <= PX + 3) && (py <= oy + 3) && (oy <= py + 3);
    wait_tick();
    step();
    if (coll) begin
      chk("over", 32'({game_over, ifa.setoff, ifa.plot, ifa.draw}), 32'(4'b1000));
      chk("over_score", 32'(score), 32'(score_m));
      repeat (3) begin
        step();
        chk("over_hold", 32'({game_over, ifa.plot, score}), 32'({1'b1, 1'b0, 8'(score_m)}));
      end
      pulse_start();
      sprite(1'b0);
    end else begin
      if (fin) score_m = (score_m >= 255) ? 255 : score_m + 1;
      chk("erase_score", 32'(score), 32'(score_m));
      sprite(1'b1);
      sprite(1'b0);
    end
    chk("wait_entry", 32'({ifa.plot, ifa.draw, ifa.setoff, game_over}), 32'(4'b0010));
  endtask

  initial begin
    int ox, oy, py;
    ifa.obs_x = 8'd200; ifa.obs_y = 7'd0; ifa.player_y = 7'd100; ifa.finish = 1'b0;
    ifb.obs_x = 8'd200; ifb.obs_y = 7'd0; ifb.player_y = 7'd100; ifb.finish = 1'b0;

    // Reset state
    #1 resetn = 1'b0;
    repeat (3) step();
    chk("reset_outs", 32'({ifa.draw, ifa.erase, ifa.plot, ifa.pix_idx, ifa.setoff,
                           ifa.frame_tick, score, game_over}), 32'd0);
    resetn = 1'b1;
    en_cnt = 0;

    // Tick during DRAW is held and honoured right after WAIT entry
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    repeat (15) step();
    chk("d2_last_px", 32'({ifb.plot, ifb.pix_idx}), 32'({1'b1, 4'd15}));
    step();
    chk("d2_wait", 32'({ifb.plot, ifb.draw, ifb.erase}), 32'd0);
    step();
    chk("d2_erase", 32'({ifb.plot, ifb.erase, ifb.pix_idx}), 32'({1'b1, 1'b1, 4'd0}));

    // First game: initial sprite then WAIT
    pulse_start();
    sprite(1'b0);
    chk("first_wait", 32'({ifa.plot, ifa.setoff, score}), 32'({1'b0, 1'b1, 8'd0}));

    // Directed outcomes
    round(50, 58, 58, 1'b1);    // clear pass, score 1
    round(12, 58, 58, 1'b1);    // collision + finish: over, score held
    round(12, 58, 56, 1'b0);    // collision
    round(12, 126, 127, 1'b0);  // bottom edge rows overlap
    round(12, 127, 125, 1'b0);  // bottom edge rows overlap
    round(255, 124, 127, 1'b1); // right edge, no overlap
    round(13, 10, 10, 1'b0);    // columns touch at 13
    round(14, 10, 10, 1'b1);    // columns just apart
    round(6, 10, 10, 1'b1);     // columns just apart on the left
    round(9, 10, 13, 1'b0);     // rows touch at 13
    round(9, 10, 14, 1'b1);     // rows just apart

    // Random placements
    for (int i = 0; i < 12; i++) begin
      ox = ($urandom_range(0, 1) == 0) ? int'($urandom_range(4, 16)) : int'($urandom_range(0, 255));
      py = int'($urandom_range(0, 127));
      oy = py + int'($urandom_range(0, 10)) - 5;
      if (oy < 0) oy = 0;
      if (oy > 127) oy = 127;
      round(ox, oy, py, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of an erase pass
    ifa.obs_x = 8'd200; ifa.finish = 1'b1;
    wait_tick();
    step();
    score_m = (score_m >= 255) ? 255 : score_m + 1;
    repeat (7) step();
    chk("pre_reset", 32'({ifa.erase, ifa.pix_idx, score}), 32'({1'b1, 4'd7, 8'(score_m)}));
    #2 resetn = 1'b0;
    #1;
    chk("async_reset", 32'({ifa.draw, ifa.erase, ifa.plot, ifa.pix_idx, ifa.setoff,
                            ifa.frame_tick, score, game_over}), 32'd0);
    repeat (2) begin
      step();
      chk("reset_noplot", 32'({ifa.plot, ifa.pix_idx}), 32'd0);
    end
    resetn = 1'b1;
    en_cnt = 0;
    score_m = 0;
    step();
    chk("post_reset_idle", 32'({ifa.setoff, ifa.plot, game_over, score}), 32'd0);

    // Score saturation over 256 cleared obstacles
    pulse_start();
    sprite(1'b0);
    for (int i = 0; i < 256; i++) round(200, 0, 100, 1'b1);
    chk("score_sat", 32'(score), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
